// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the WB stage / MDU / debug unit and the register-file write arbiter.
// The arbiter connects to the slave modport; the writers and decode drive the master side.
interface rf_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              mdu_issue;
    logic [ADDR_W-1:0] mdu_issue_rd;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ack;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              hazard_a;
    logic              hazard_b;

    modport master (
        output wb_we, wb_addr, wb_data,
        output mdu_issue, mdu_issue_rd, mdu_valid, mdu_addr, mdu_data,
        output dbg_req, dbg_addr, dbg_data,
        output rd_addr_a, rd_addr_b,
        input  mdu_ready, dbg_ack, rf_we, rf_addr, rf_data, hazard_a, hazard_b
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  mdu_issue, mdu_issue_rd, mdu_valid, mdu_addr, mdu_data,
        input  dbg_req, dbg_addr, dbg_data,
        input  rd_addr_a, rd_addr_b,
        output mdu_ready, dbg_ack, rf_we, rf_addr, rf_data, hazard_a, hazard_b
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB always wins, MDU hold and debug share idle cycles.
// Define RF_ARB_DBG_EN to build the debug requester; without it priority is simply WB > MDU.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic               clock,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic              mhValid, mhValidNext;
    logic [ADDR_W-1:0] mhAddr, mhAddrNext;
    logic [DATA_W-1:0] mhData, mhDataNext;
    logic [NumRegs-1:0] busy, busyNext;
    logic              mduTake;
    logic              grantMdu;
    logic              wrValid;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;

    assign bus.mdu_ready = !mhValid && !reset;
    assign mduTake       = bus.mdu_valid && bus.mdu_ready;

`ifdef RF_ARB_DBG_EN
    logic dbgDone, dbgDoneNext;
    logic dbgAck;
    logic rrLast, rrLastNext;  // 1: debug was served last, so MDU goes next
    logic dbgElig;
    logic grantDbg;

    assign dbgElig = bus.dbg_req && !dbgDone;

    always_comb begin
        grantMdu = 1'b0;
        grantDbg = 1'b0;
        if (!reset && !bus.wb_we) begin
            if (mhValid && dbgElig) begin
                grantMdu = rrLast;
                grantDbg = !rrLast;
            end else begin
                grantMdu = mhValid;
                grantDbg = dbgElig;
            end
        end
    end

    always_comb begin
        dbgDoneNext = dbgDone;
        rrLastNext  = rrLast;
        if (grantDbg) begin
            dbgDoneNext = 1'b1;
            rrLastNext  = 1'b1;
        end else if (!bus.dbg_req) begin
            dbgDoneNext = 1'b0;
        end
        if (grantMdu) begin
            rrLastNext = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dbgDone <= 1'b0;
            dbgAck  <= 1'b0;
            rrLast  <= 1'b1;
        end else begin
            dbgDone <= dbgDoneNext;
            dbgAck  <= grantDbg;
            rrLast  <= rrLastNext;
        end
    end

    assign bus.dbg_ack = dbgAck;
`else
    logic unusedDbg;
    assign unusedDbg   = ^{bus.dbg_req, bus.dbg_addr, bus.dbg_data};
    assign grantMdu    = !reset && !bus.wb_we && mhValid;
    assign bus.dbg_ack = 1'b0;
`endif

    always_comb begin
        wrValid = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        if (bus.wb_we) begin
            wrValid = 1'b1;
            wrAddr  = bus.wb_addr;
            wrData  = bus.wb_data;
        end else if (grantMdu) begin
            wrValid = 1'b1;
            wrAddr  = mhAddr;
            wrData  = mhData;
        end
`ifdef RF_ARB_DBG_EN
        else if (grantDbg) begin
            wrValid = 1'b1;
            wrAddr  = bus.dbg_addr;
            wrData  = bus.dbg_data;
        end
`endif
    end

    // r0 entries are consumed like any other but never reach the register file
    assign bus.rf_we   = wrValid && (wrAddr != '0);
    assign bus.rf_addr = wrAddr;
    assign bus.rf_data = wrData;

    always_comb begin
        mhValidNext = mhValid;
        mhAddrNext  = mhAddr;
        mhDataNext  = mhData;
        if (grantMdu) begin
            mhValidNext = 1'b0;
        end
        if (mduTake) begin
            mhValidNext = 1'b1;
            mhAddrNext  = bus.mdu_addr;
            mhDataNext  = bus.mdu_data;
        end
    end

    // Clear first, then set, so a same-edge issue to the committing register stays busy
    always_comb begin
        busyNext = busy;
        if (grantMdu) begin
            busyNext[mhAddr] = 1'b0;
        end
        if (bus.mdu_issue && (bus.mdu_issue_rd != '0)) begin
            busyNext[bus.mdu_issue_rd] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mhValid <= 1'b0;
            busy    <= '0;
        end else begin
            mhValid <= mhValidNext;
            busy    <= busyNext;
        end
        mhAddr <= mhAddrNext;
        mhData <= mhDataNext;
    end

    assign bus.hazard_a = busy[bus.rd_addr_a];
    assign bus.hazard_b = busy[bus.rd_addr_b];
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between three writers: pipeline writeback (WB), the multi-cycle multiply/divide unit (MDU) and the debug write path (DBG). WB always wins; MDU and DBG are buffered and served round-robin in WB-idle cycles. A per-register busy scoreboard tracks MDU destinations still in flight, so decode can stall on read-after-write hazards. The block sits between the WB stage / MDU / debug unit and the register file's write port. The register file commits on the falling clock edge.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (2^ADDR_W registers)

- clock  in  1  rising-edge clock for all state
- reset  in  1  reset, synchronous, active-high
- wb_we / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  WB write request, never stalled
- mdu_issue  in  1  MDU op issued this cycle
- mdu_issue_rd  in  ADDR_W  destination of the issued op
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  holding register free
- mdu_addr / mdu_data  in  ADDR_W / DATA_W  MDU result
- dbg_req  in  1  level request, held until dbg_ack
- dbg_addr / dbg_data  in  ADDR_W / DATA_W  debug write
- dbg_ack  out  1  one-cycle pulse, debug write committed
- rf_we / rf_addr / rf_data  out  1 / ADDR_W / DATA_W  to register-file write port
- rd_addr_a / rd_addr_b  in  ADDR_W  decode read addresses
- hazard_a / hazard_b  out  1  addressed register has an MDU write in flight

## Operation
- MDU holding register (`mh_valid`, `mh_addr`, `mh_data`):
  - Captured at the posedge when `mdu_valid && mdu_ready`.
  - `mdu_ready = !mh_valid && !reset`.
- Debug path: `dbg_req` is eligible when `dbg_req && !dbg_done`.
- Per-cycle grant, combinational to the `rf_*` outputs:
  - `wb_we=1`: grant WB.
  - Otherwise, if exactly one of MDU hold / DBG is eligible, grant it.
  - Otherwise, if both are eligible, grant the one not served last (the `rr_last` bit).
  - With nothing eligible, `rf_we=0`.
- Commit bookkeeping at the posedge closing a grant cycle:
  - MDU grant: clear `mh_valid` and set `rr_last=MDU`.
  - DBG grant: set `dbg_done` and `rr_last=DBG`; `dbg_ack=1` for the next cycle.
  - `dbg_done` clears on the first posedge that sees `dbg_req=0`.
- Address 0: a granted entry is consumed normally, but `rf_we` is forced to 0 (r0 is hard-wired to zero).
- Scoreboard `busy[2^ADDR_W-1:1]`:
  - `mdu_issue` with a nonzero rd sets `busy[rd]`.
  - An MDU grant clears `busy[mh_addr]`.
  - Set and clear of the same register at the same posedge: set wins.
- `hazard_x = busy[rd_addr_x]`, combinational; always 0 for address 0.
- A WB write to a busy register is performed and leaves `busy` unchanged.

## Timing
- Reset values: `mh_valid=0`, `busy` all 0, `rr_last=DBG` (MDU served first), `dbg_done=0`, `dbg_ack=0`, `mdu_ready=0` while reset is high.
- Output levels during reset: `rf_we` follows the grant logic, so `rf_we = wb_we && wb_addr!=0`. The WB stage is already held in reset.
- WB latency is 0: committed at the negedge of the cycle `wb_we` is high.
- MDU minimum latency: handshake at posedge N, `rf_we` in cycle N+1, committed at the negedge of N+1.
  - `mdu_ready` returns to 1 in cycle N+2.
  - Sustained MDU throughput is one result per 2 cycles.
- DBG: grant in cycle N, `dbg_ack=1` in cycle N+1.
  - A `dbg_req` still high in N+1 is not granted again.
- Starvation bound: with WB idle at least every other cycle, each eligible requester is granted within 2 WB-idle cycles.
- Reset mid-operation: a held MDU result is discarded, `busy` is cleared and a pending `dbg_ack` is dropped.

## Configuration
- `RF_ARB_DBG_EN` defined: DBG requester present as described.
- `RF_ARB_DBG_EN` undefined:
  - The DBG requester is compiled out; `dbg_req`, `dbg_addr` and `dbg_data` are ignored.
  - `dbg_ack` is tied to 0 and `rr_last` is removed.
  - Priority becomes WB > MDU.

## Test plan
- MDU alone: issue rd=5, then `mdu_valid` addr=5 data=0x12345678 -> `hazard_a`=1 for `rd_addr_a`=5 until the commit; `rf_we`=1, `rf_addr`=5, `rf_data`=0x12345678 the cycle after the handshake; `hazard_a`=0 the following cycle.
- WB contention: MDU held for r7 while `wb_we` is high 3 cycles (r3, r4, r6) -> WB writes r3/r4/r6 back to back; the r7 write happens in the first cycle `wb_we`=0; `mdu_ready` stays 0 until then.
- Round-robin: MDU hold (r8) and `dbg_req` (r9, 0xDEAD) both pending, WB idle, after reset -> r8 first, r9 next cycle; `dbg_ack` pulses one cycle after the r9 write; repeating the pair with `rr_last=DBG` -> MDU first again.
- r0 and set/clear collision: MDU result to r0 -> consumed, `mdu_ready` returns, `rf_we`=0. A new `mdu_issue` rd=10 in the same cycle as the r10 commit -> `busy[10]` stays 1.
- Reset mid-flight: `mh_valid`=1 and `busy[12]`=1, then reset is asserted 1 cycle -> no MDU write occurs, `hazard` is 0 for r12, and `mdu_ready`=1 the first cycle after reset.
- Build without `RF_ARB_DBG_EN`: `dbg_req`=1 held 10 cycles -> no debug write and `dbg_ack` stays 0; MDU writes are unaffected.
